mem_loader: RTL and testbench

- Write-side companion to the synchronous-read program ROM/RAM.
- Accepts a framed byte stream (e.g. from a UART receiver) over a valid/ready handshake.
- Assembles little-endian words from the bytes and issues single-cycle write strobes into the word-addressed memory.
- Used to load program images into the memory that the core later reads.

---
 rtl/mem_loader.sv | 137 +++++++++++++
 tb/tb_mem_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Framed byte-stream loader: assembles little-endian words and issues write strobes
// into a word-addressed memory. Optional frame checksum: MEM_LOADER_CHECKSUM_EN.
module mem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [15:0] ADDR_MASK = 16'((32'd1 << ADDR_WIDTH) - 1);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [3:0] {
        IDLE, ADDR0, ADDR1, CNT0, CNT1, DATA, WRITE,
`ifdef MEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

`ifdef MEM_LOADER_CHECKSUM_EN
    localparam state_t TAIL = CSUM;
`else
    localparam state_t TAIL = DONE;
`endif

    state_t                  state, state_nxt;
    logic [15:0]             addr_q;
    logic [15:0]             cnt_q;
    logic [DATA_WIDTH-1:0]   word_q, word_nxt;
    logic [2:0]              lane_q;
    logic                    fire, last_lane;

    assign in_ready  = resetn && (state != WRITE) && (state != DONE);
    assign fire      = in_valid && in_ready;
    assign last_lane = (lane_q == 3'(BYTES - 1));
    assign mem_we    = (state == WRITE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        word_nxt = word_q;
        for (int i = 0; i < BYTES; i++)
            if (lane_q == 3'(i)) word_nxt[i*8 +: 8] = in_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (fire && in_data == SYNC) state_nxt = ADDR0;
            ADDR0: if (fire) state_nxt = ADDR1;
            ADDR1: if (fire) state_nxt = CNT0;
            CNT0:  if (fire) state_nxt = CNT1;
            CNT1:  if (fire) state_nxt = ({in_data, cnt_q[7:0]} == 16'd0) ? TAIL : DATA;
            DATA:  if (fire && last_lane) state_nxt = WRITE;
            WRITE: state_nxt = (cnt_q == 16'd1) ? TAIL : DATA;
`ifdef MEM_LOADER_CHECKSUM_EN
            CSUM:  if (fire) state_nxt = DONE;
`endif
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            lane_q    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ADDR0: if (fire) addr_q <= {8'h00, in_data};
                ADDR1: if (fire) addr_q <= {in_data, addr_q[7:0]} & ADDR_MASK;
                CNT0:  if (fire) cnt_q[7:0]  <= in_data;
                CNT1:  if (fire) cnt_q[15:8] <= in_data;
                DATA: if (fire) begin
                    word_q <= word_nxt;
                    lane_q <= last_lane ? 3'd0 : lane_q + 3'd1;
                    // Latch the strobe payload now so it is stable for the whole WRITE cycle
                    if (last_lane) begin
                        mem_wdata <= word_nxt;
                        mem_addr  <= addr_q[ADDR_WIDTH-1:0];
                    end
                end
                WRITE: begin
                    addr_q <= (addr_q + 16'd1) & ADDR_MASK;
                    cnt_q  <= cnt_q - 16'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_nxt;
    logic       error_q;

    assign sum_nxt = sum_q + in_data;
    assign error   = error_q;

    // Sum covers every byte after sync; the CSUM byte itself must bring it to zero
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sum_q   <= '0;
            error_q <= 1'b0;
        end else if (fire) begin
            if (state == IDLE) begin
                if (in_data == SYNC) begin
                    sum_q   <= '0;
                    error_q <= 1'b0;
                end
            end else begin
                sum_q <= sum_nxt;
                if (state == CSUM && sum_nxt != 8'h00) error_q <= 1'b1;
            end
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader (DATA_WIDTH=32, ADDR_WIDTH=8): frame table plus
// hand sequences for reset and, with MEM_LOADER_CHECKSUM_EN, checksum handling.
module tb_mem_loader;
    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;

    logic [7:0]  wq_a[$];
    logic [31:0] wq_d[$];
    int          done_cnt = 0;
    int          rdy_viol = 0;

    mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Observe on the falling edge, well away from state changes
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (mem_we === 1'b1) begin
                wq_a.push_back(mem_addr);
                wq_d.push_back(mem_wdata);
                if (in_ready !== 1'b0) rdy_viol++;
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    typedef struct {
        logic [7:0]  b[16];
        int          len;
        bit          gap;
        int          nw;
        logic [7:0]  wa[2];
        logic [31:0] wd[2];
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: in_ready stuck at %b, expected 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    // Sends b[0..len-1]; with the checksum build, appends the byte that zeroes the sum
    task automatic send_frame(input logic [7:0] b[16], input int len, input bit gap, input bit add_csum);
        logic [7:0] s = 8'h00;
        bit synced = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (synced) s = s + b[i];
            else if (b[i] == 8'hA5) synced = 1'b1;
            send_byte(b[i], gap);
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        if (add_csum) send_byte(8'h00 - s, gap);
`else
        if (add_csum && s == 8'hFF) in_data = 8'h00;
`endif
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    vec_t vecs[4];
    logic [7:0] fr[16];

    initial begin
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        vecs[0].b  = '{8'hA5,8'h10,8'h00,8'h02,8'h00,8'h11,8'h22,8'h33,8'h44,8'h55,8'h66,8'h77,8'h88,8'h00,8'h00,8'h00};
        vecs[0].len = 13; vecs[0].gap = 1'b0; vecs[0].nw = 2;
        vecs[0].wa = '{8'h10, 8'h11}; vecs[0].wd = '{32'h44332211, 32'h88776655};

        vecs[1].b  = '{8'h00,8'hFF,8'hA5,8'h05,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        vecs[1].len = 7; vecs[1].gap = 1'b0; vecs[1].nw = 0;
        vecs[1].wa = '{8'h00, 8'h00}; vecs[1].wd = '{32'h0, 32'h0};

        vecs[2].b  = '{8'hA5,8'hFF,8'h00,8'h02,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h00,8'h00,8'h00};
        vecs[2].len = 13; vecs[2].gap = 1'b0; vecs[2].nw = 2;
        vecs[2].wa = '{8'hFF, 8'h00}; vecs[2].wd = '{32'h04030201, 32'h08070605};

        vecs[3] = vecs[0];
        vecs[3].gap = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        resetn = 1'b1;
        #1 chk("post_rst_in_ready", in_ready, 1);

        for (int v = 0; v < 4; v++) begin
            wq_a.delete(); wq_d.delete();
            done_cnt = 0; rdy_viol = 0;
            send_frame(vecs[v].b, vecs[v].len, vecs[v].gap, 1'b1);
            if (vecs[v].nw == 0) chk($sformatf("v%0d_done_next", v), done, 1);
            wait_done();
            chk($sformatf("v%0d_nwrites", v), wq_a.size(), vecs[v].nw);
            for (int w = 0; w < vecs[v].nw && w < wq_a.size(); w++) begin
                chk($sformatf("v%0d_w%0d_addr", v, w), wq_a[w], vecs[v].wa[w]);
                chk($sformatf("v%0d_w%0d_data", v, w), wq_d[w], vecs[v].wd[w]);
            end
            chk($sformatf("v%0d_done_cnt", v), done_cnt, 1);
            chk($sformatf("v%0d_ready_in_write", v), rdy_viol, 0);
            chk($sformatf("v%0d_busy_after", v), busy, 0);
        end

        // Reset in the middle of a partial word
        wq_a.delete(); wq_d.delete(); done_cnt = 0;
        fr = '{8'hA5,8'h20,8'h00,8'h01,8'h00,8'hAA,8'hBB,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        send_frame(fr, 7, 1'b0, 1'b0);
        @(negedge clk) resetn = 1'b0;
        @(negedge clk) resetn = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_error", error, 0);
        repeat (3) @(negedge clk);
        chk("midrst_nwrites", wq_a.size(), 0);
        chk("midrst_done", done_cnt, 0);
        fr = '{8'hA5,8'h30,8'h00,8'h01,8'h00,8'h01,8'h02,8'h03,8'h04,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        send_frame(fr, 9, 1'b0, 1'b1);
        wait_done();
        chk("resume_nwrites", wq_a.size(), 1);
        if (wq_a.size() > 0) begin
            chk("resume_addr", wq_a[0], 8'h30);
            chk("resume_data", wq_d[0], 32'h04030201);
        end

`ifdef MEM_LOADER_CHECKSUM_EN
        wq_a.delete(); wq_d.delete(); done_cnt = 0;
        fr = '{8'hA5,8'h01,8'h00,8'h01,8'h00,8'h01,8'h00,8'h00,8'h00,8'hFD,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        send_frame(fr, 10, 1'b0, 1'b0);
        chk("csum_ok_done", done, 1);
        chk("csum_ok_error", error, 0);
        wait_done();
        chk("csum_ok_nwrites", wq_a.size(), 1);

        wq_a.delete(); wq_d.delete(); done_cnt = 0;
        fr[9] = 8'h00;
        send_frame(fr, 10, 1'b0, 1'b0);
        chk("csum_bad_done", done, 1);
        chk("csum_bad_error", error, 1);
        wait_done();
        chk("csum_bad_nwrites", wq_a.size(), 1);
        chk("csum_bad_error_held", error, 1);
        send_byte(8'hA5, 1'b0);
        chk("csum_sync_clears", error, 0);
        @(negedge clk) resetn = 1'b0;
        @(negedge clk) resetn = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end
endmodule
